// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared state encoding and PC defaults for fetch_sequencer
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEFAULT      = 32'd4;

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch FSM with a one-deep hold register
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] PC_STEP      = PC_STEP_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] PCResult,
    output logic [31:0] Address,
    output logic        PCWrite,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    input  logic        Stall,
    output logic        InstrValid,
    output logic [31:0] Instruction,
    output logic [31:0] InstrPC,
    input  logic        InstrReady,
    output logic [31:0] FetchCount
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic         w_accept;
    logic         w_transfer;

    assign w_accept   = (r_state == S_REQ) && IMemAck && !Redirect;
    assign w_transfer = (r_state == S_HOLD) && InstrValid && InstrReady && !Stall && !Redirect;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        PCWrite      = 1'b0;
        Address      = PCResult + PC_STEP;
        IMemReq      = (r_state == S_REQ) || (r_state == S_DRAIN);
        // IDLE only follows reset, where the PC register already holds the vector
        IMemAddr     = (r_state == S_IDLE) ? RESET_VECTOR : PCResult;

        case (r_state)
            S_IDLE:  w_next_state = S_REQ;
            S_REQ: begin
                if (Redirect) begin
                    w_next_state = IMemAck ? S_REQ : S_DRAIN;
                end else if (IMemAck) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (Redirect || w_transfer) begin
                    w_next_state = S_REQ;
                end
            end
            S_DRAIN: begin
                if (!Redirect && IMemAck) begin
                    w_next_state = S_REQ;
                end
            end
            default: w_next_state = S_IDLE;
        endcase

        // Redirect wins over the sequential increment; reset masks any PC load
        if (Redirect) begin
            Address = RedirectTarget & ~32'h3;
            PCWrite = Reset_n;
        end else if (w_accept) begin
            PCWrite = Reset_n;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            InstrValid  <= 1'b0;
            Instruction <= 32'h0;
            InstrPC     <= 32'h0;
            FetchCount  <= 32'h0;
        end else begin
            if (Redirect || w_transfer) begin
                InstrValid <= 1'b0;
            end else if (w_accept) begin
                InstrValid  <= 1'b1;
                Instruction <= IMemData;
                InstrPC     <= PCResult;
            end
            if (w_transfer) begin
                FetchCount <= FetchCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
    import fetch_seq_pkg::*;

    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] STEP = 32'd4;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [31:0] PCResult;
    logic [31:0] Address;
    logic        PCWrite;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic        Stall;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic        InstrReady;
    logic [31:0] FetchCount;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    fetch_sequencer #(.RESET_VECTOR(RV), .PC_STEP(STEP)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .PCResult(PCResult), .Address(Address),
        .PCWrite(PCWrite), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
        .IMemData(IMemData), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
        .Stall(Stall), .InstrValid(InstrValid), .Instruction(Instruction),
        .InstrPC(InstrPC), .InstrReady(InstrReady), .FetchCount(FetchCount)
    );

    always #5 Clk = ~Clk;

    // Program counter register owned by the surrounding pipeline
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            PCResult <= RV;
        end else if (PCWrite) begin
            PCResult <= Address;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic take;
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("xfer_instr", Instruction, e.data);
            chk("xfer_pc", InstrPC, e.pc);
        end
    endtask

    // Entered just after a clock edge with the FSM in REQ; leaves it in REQ again
    task automatic fetch_one(input logic [31:0] d, input logic [31:0] pc, input int stalls);
        logic [31:0] nxt;
        exp_t        e;
        nxt = pc + STEP;
        IMemAck = 1'b0; Redirect = 1'b0; Stall = 1'b0; InstrReady = 1'b1;
        settle;
        chk("req_on", IMemReq, 1'b1);
        chk("req_addr", IMemAddr, pc);
        chk("req_nowrite", PCWrite, 1'b0);
        step;
        IMemAck = 1'b1; IMemData = d;
        settle;
        chk("ack_pcwrite", PCWrite, 1'b1);
        chk("ack_address", Address, nxt);
        e.data = d; e.pc = pc;
        sb.push_back(e);
        step;
        IMemAck = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            Stall = 1'b1;
            settle;
            chk("stall_valid", InstrValid, 1'b1);
            chk("stall_instr", Instruction, d);
            chk("stall_pc", InstrPC, pc);
            chk("stall_req", IMemReq, 1'b0);
            chk("stall_pcwrite", PCWrite, 1'b0);
            step;
        end
        Stall = 1'b0;
        settle;
        chk("hold_valid", InstrValid, 1'b1);
        chk("hold_req", IMemReq, 1'b0);
        take();
        step;
    endtask

    initial begin
        Reset_n = 1'b0; IMemAck = 1'b0; IMemData = 32'h0; Redirect = 1'b1;
        RedirectTarget = 32'h40; Stall = 1'b0; InstrReady = 1'b1;
        step;
        settle;
        chk("rst_valid", InstrValid, 1'b0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_pc", InstrPC, 32'h0);
        chk("rst_count", FetchCount, 32'h0);
        chk("rst_req", IMemReq, 1'b0);
        chk("rst_pcwrite", PCWrite, 1'b0);
        Redirect = 1'b0;

        // First cycle after release is IDLE: a stray ack must be ignored
        step;
        Reset_n = 1'b1; IMemAck = 1'b1; IMemData = 32'hBAD;
        settle;
        chk("idle_req", IMemReq, 1'b0);
        chk("idle_pcwrite", PCWrite, 1'b0);
        step;
        IMemAck = 1'b0;

        fetch_one(32'h11, 32'h0, 0);
        fetch_one(32'h22, 32'h4, 5);
        fetch_one(32'h33, 32'h8, 0);
        chk("count3", FetchCount, 32'd3);
        chk("post3_valid", InstrValid, 1'b0);

        // Redirect with no ack -> DRAIN, late ack discarded
        Redirect = 1'b1; RedirectTarget = 32'h103;
        settle;
        chk("rd1_pcwrite", PCWrite, 1'b1);
        chk("rd1_address", Address, 32'h100);
        step;
        Redirect = 1'b0;
        settle;
        chk("drain_req", IMemReq, 1'b1);
        chk("drain_nowrite", PCWrite, 1'b0);
        step;
        IMemAck = 1'b1; IMemData = 32'hDEAD;
        settle;
        chk("drain_ack_nowrite", PCWrite, 1'b0);
        step;
        IMemAck = 1'b0;
        settle;
        chk("after_drain_addr", IMemAddr, 32'h100);
        chk("after_drain_valid", InstrValid, 1'b0);
        chk("after_drain_instr", Instruction, 32'h33);

        // Redirect coinciding with ack -> data dropped, stay in REQ
        Redirect = 1'b1; RedirectTarget = 32'h200; IMemAck = 1'b1; IMemData = 32'h55;
        settle;
        chk("rd2_pcwrite", PCWrite, 1'b1);
        chk("rd2_address", Address, 32'h200);
        step;
        Redirect = 1'b0; IMemAck = 1'b0;
        settle;
        chk("rd2_valid", InstrValid, 1'b0);
        chk("rd2_req", IMemReq, 1'b1);
        chk("rd2_addr", IMemAddr, 32'h200);
        chk("rd2_instr", Instruction, 32'h33);
        fetch_one(32'h44, 32'h200, 0);

        // Wrap of the sequential PC
        Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFFC; IMemAck = 1'b1; IMemData = 32'h99;
        settle;
        chk("rd3_address", Address, 32'hFFFF_FFFC);
        step;
        Redirect = 1'b0; IMemAck = 1'b0;
        fetch_one(32'h66, 32'hFFFF_FFFC, 0);
        chk("wrap_pc", PCResult, 32'h0);
        chk("count5", FetchCount, 32'd5);

        // Redirect while holding an unaccepted instruction
        IMemAck = 1'b0; InstrReady = 1'b0;
        settle;
        step;
        IMemAck = 1'b1; IMemData = 32'h77;
        settle;
        chk("h_ack_address", Address, 32'h4);
        step;
        IMemAck = 1'b0;
        settle;
        chk("h_valid", InstrValid, 1'b1);
        chk("h_instr", Instruction, 32'h77);
        step;
        settle;
        chk("h_wait_valid", InstrValid, 1'b1);
        chk("h_wait_nowrite", PCWrite, 1'b0);
        Redirect = 1'b1; RedirectTarget = 32'h300;
        settle;
        chk("h_rd_pcwrite", PCWrite, 1'b1);
        chk("h_rd_address", Address, 32'h300);
        step;
        Redirect = 1'b0; InstrReady = 1'b1;
        settle;
        chk("h_rd_valid", InstrValid, 1'b0);
        chk("h_rd_count", FetchCount, 32'd5);
        chk("h_rd_req", IMemReq, 1'b1);
        chk("h_rd_addr", IMemAddr, 32'h300);

        // Asynchronous reset in the middle of a request
        Reset_n = 1'b0;
        settle;
        chk("mid_rst_req", IMemReq, 1'b0);
        chk("mid_rst_valid", InstrValid, 1'b0);
        chk("mid_rst_count", FetchCount, 32'h0);
        chk("mid_rst_pcwrite", PCWrite, 1'b0);
        step;
        Reset_n = 1'b1;
        settle;
        chk("mid_rst_idle_req", IMemReq, 1'b0);
        step;
        fetch_one(32'h88, RV, 0);
        chk("final_count", FetchCount, 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00000000, SHALL be the first fetch address expected after reset.
REQ-002 Parameter PC_STEP, default 4, SHALL be the sequential PC increment in bytes.
REQ-003 Clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 PCResult  in  32  SHALL be the current PC from the program counter register.
REQ-006 Address  out  32  SHALL be the next-PC value driven to the program counter register.
REQ-007 PCWrite  out  1  SHALL be the program counter load enable.
REQ-008 IMemReq  out  1  SHALL be the instruction memory request.
REQ-009 IMemAddr  out  32  SHALL be the instruction memory address.
REQ-010 IMemAck  in  1  SHALL signal that the memory has returned data, valid for one cycle.
REQ-011 IMemData  in  32  SHALL be the returned instruction word.
REQ-012 Redirect  in  1  SHALL be a one-cycle branch/jump redirect pulse.
REQ-013 RedirectTarget  in  32  SHALL be the redirect destination.
REQ-014 Stall  in  1  SHALL freeze handoff of the held instruction.
REQ-015 InstrValid  out  1  SHALL indicate that Instruction/InstrPC are valid.
REQ-016 Instruction  out  32  SHALL be the registered fetched word.
REQ-017 InstrPC  out  32  SHALL be the registered PC of Instruction.
REQ-018 InstrReady  in  1  SHALL indicate that the decode stage accepts the instruction.
REQ-019 FetchCount  out  32  SHALL count accepted instructions.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, HOLD and DRAIN.
REQ-021 IDLE SHALL last exactly one cycle after reset release and then go to REQ.
REQ-022 In REQ and DRAIN, IMemReq SHALL be 1 and IMemAddr SHALL equal PCResult; in all other states IMemReq SHALL be 0.
REQ-023 REQ with IMemAck=1 and no Redirect SHALL:
- register IMemData into Instruction and PCResult into InstrPC;
- set InstrValid=1 on the next cycle;
- assert PCWrite=1 with Address=PCResult+PC_STEP in the same cycle (combinational);
- go to HOLD.
REQ-024 REQ with IMemAck=0 and no Redirect SHALL remain in REQ, with PCWrite=0.
REQ-025 In HOLD, a transfer SHALL occur when InstrValid=1, InstrReady=1 and Stall=0; on transfer, InstrValid SHALL clear next cycle, FetchCount SHALL increment, and the FSM SHALL go to REQ.
REQ-026 HOLD with Stall=1 or InstrReady=0 SHALL hold all outputs unchanged.
REQ-027 Redirect=1 in any state SHALL:
- assert PCWrite=1 that cycle;
- drive Address = {RedirectTarget[31:2], 2'b00};
- clear InstrValid next cycle without incrementing FetchCount.
Redirect has priority over Stall, IMemAck and transfer.
REQ-028 The next state after a Redirect SHALL be:
- IDLE -> REQ; HOLD -> REQ;
- REQ with IMemAck=1 -> REQ, with the returned data discarded;
- REQ with IMemAck=0 -> DRAIN;
- DRAIN -> DRAIN.
REQ-029 In DRAIN, IMemAck=1 SHALL discard IMemData, leave Instruction/InstrPC unchanged and go to REQ; PCWrite SHALL be 0 unless Redirect=1.
REQ-030 At most one memory request SHALL be outstanding.
REQ-031 PC arithmetic SHALL be modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000).
REQ-032 FetchCount SHALL wrap from 0xFFFFFFFF to 0.
REQ-033 PCWrite SHALL be 0 whenever neither REQ-023 nor REQ-027 applies.

Reset
REQ-034 Reset_n=0 SHALL immediately set state=IDLE, InstrValid=0, Instruction=0, InstrPC=0 and FetchCount=0, and force IMemReq=0 and PCWrite=0, regardless of Clk.
REQ-035 Reset asserted mid-request SHALL abandon the request; an IMemAck arriving in the first post-reset cycle SHALL be ignored.
REQ-036 The program counter register SHALL be reset to RESET_VECTOR by the same reset event; this block SHALL NOT drive Address for reset.

Structure
REQ-037 A shared package fetch_seq_pkg SHALL hold the FSM state encoding, PC_STEP and the RESET_VECTOR default.
REQ-038 The block SHALL be a single module with no sub-module; the state register, hold register and counter are inline.

Verification
REQ-039 Reset, then IMemAck one cycle after each request with data 0x11,0x22,0x33 and InstrReady=1 -> InstrPC 0x0,0x4,0x8; PCWrite pulses with Address 0x4,0x8,0xC; FetchCount=3.
REQ-040 Stall=1 for 5 cycles in HOLD at PC 0x4 -> Instruction/InstrPC stable, IMemReq=0, PCWrite=0; the transfer occurs on the cycle Stall drops.
REQ-041 Redirect to 0x103 in REQ with IMemAck=0 -> Address=0x100, PCWrite=1; DRAIN; late ack data 0xDEAD discarded; the next IMemAddr is 0x100.
REQ-042 Redirect to 0x200 in the same cycle as IMemAck in REQ -> data discarded; InstrValid=0; the next request is to 0x200.
REQ-043 Redirect to 0xFFFFFFFC, ack -> PCWrite with Address=0x00000000.
REQ-044 Reset_n pulsed low mid-REQ -> IMemReq=0 and InstrValid=0 immediately, FetchCount=0; refetch starts from RESET_VECTOR after the IDLE cycle.
